// File: rtl/result_unpack.sv
// Result unpacker: buffers 129-bit pipeline results in a small FIFO and streams each block
// as 32-bit words, MSW first. Optional block/packet counters via RESULT_UNPACK_BLK_CNT_EN.
module result_unpack #(
  parameter int BLOCK_LENGTH = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int PTR_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    res_valid,
  input  logic [BLOCK_LENGTH:0]   res_data,
  output logic                    stall,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [PTR_WIDTH:0]      fifo_cnt
`ifdef RESULT_UNPACK_BLK_CNT_EN
  ,
  output logic [31:0]             blk_cnt,
  output logic [15:0]             pkt_cnt
`endif
);

  localparam int WORDS = BLOCK_LENGTH / WORD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [PTR_WIDTH:0]   DEPTH    = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  logic [BLOCK_LENGTH:0]  mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]     count_q, count_d;
  logic [IDX_W-1:0]       word_idx_q, word_idx_d;

  logic                   full;
  logic                   push;
  logic                   fire;
  logic                   pop;
  logic [BLOCK_LENGTH:0]  head;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    full      = (count_q == DEPTH);
    push      = res_valid & ~full;
    head      = mem_q[rd_ptr_q];
    out_valid = (count_q != '0);
    fire      = out_valid & out_ready;
    pop       = fire & (word_idx_q == LAST_IDX);

    stall     = full;
    fifo_cnt  = count_q;
    out_data  = '0;
    if (out_valid) begin
      out_data = head[BLOCK_LENGTH - int'(word_idx_q) * WORD_WIDTH -: WORD_WIDTH];
    end
    out_last  = out_valid & (word_idx_q == LAST_IDX) & head[0];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
    end
    if (fire) begin
      word_idx_d = pop ? '0 : word_idx_q + IDX_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (PTR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over any push/pop in the same cycle; a half-sent block is dropped.
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_idx_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q] <= res_data;
    end
  end

`ifdef RESULT_UNPACK_BLK_CNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q + 32'(pop);
    pkt_cnt_d = pkt_cnt_q + 16'(pop & head[0]);
    if (clr) begin
      blk_cnt_d = '0;
      pkt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_result_unpack.sv
// Directed bench for result_unpack: vector table for single-block and backpressure cycles,
// hand sequences for fill/stall, pointer wrap, clr, async reset and optional counters.
module tb_result_unpack;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         res_valid;
  logic [128:0] res_data;
  logic         stall;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [2:0]   fifo_cnt;
`ifdef RESULT_UNPACK_BLK_CNT_EN
  logic [31:0]  blk_cnt;
  logic [15:0]  pkt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  result_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .res_valid (res_valid),
    .res_data  (res_data),
    .stall     (stall),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .fifo_cnt  (fifo_cnt)
`ifdef RESULT_UNPACK_BLK_CNT_EN
    ,
    .blk_cnt   (blk_cnt),
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rv;
    logic [128:0] data;
    logic         ordy;
    logic         ov;
    logic [31:0]  od;
    logic         last;
    logic [2:0]   cnt;
    logic         stall;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wd(input int k, input int w);
    return {8'(k), 8'(w), 16'h5A5A};
  endfunction

  function automatic logic [128:0] mk(input int k, input logic eop);
    return {wd(k, 0), wd(k, 1), wd(k, 2), wd(k, 3), eop};
  endfunction

  function automatic vec_t v(input logic rv, input logic [128:0] data, input logic ordy,
                             input logic ov, input logic [31:0] od, input logic last,
                             input logic [2:0] cnt, input logic st);
    vec_t r;
    r.rv = rv; r.data = data; r.ordy = ordy; r.ov = ov;
    r.od = od; r.last = last; r.cnt = cnt; r.stall = st;
    return r;
  endfunction

  logic [128:0] blk_a;
  logic [128:0] blk_b;
  logic [31:0]  exp_q [$];
  int           n_last;
  int           n_words;
  int           pushed;

  initial begin
    blk_a = {128'h681EDF34_D206965E_86B3E94F_536E4246, 1'b1};
    blk_b = {128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0};
    vecs[0]  = v(1, blk_a, 1, 0, 32'h0,        0, 0, 0);
    vecs[1]  = v(0, '0,    1, 1, 32'h681EDF34, 0, 1, 0);
    vecs[2]  = v(0, '0,    1, 1, 32'hD206965E, 0, 1, 0);
    vecs[3]  = v(0, '0,    1, 1, 32'h86B3E94F, 0, 1, 0);
    vecs[4]  = v(0, '0,    1, 1, 32'h536E4246, 1, 1, 0);
    vecs[5]  = v(1, blk_b, 1, 0, 32'h0,        0, 0, 0);
    vecs[6]  = v(0, '0,    1, 1, 32'h00112233, 0, 1, 0);
    vecs[7]  = v(0, '0,    0, 1, 32'h44556677, 0, 1, 0);
    vecs[8]  = v(0, '0,    0, 1, 32'h44556677, 0, 1, 0);
    vecs[9]  = v(0, '0,    1, 1, 32'h44556677, 0, 1, 0);
    vecs[10] = v(0, '0,    1, 1, 32'h8899AABB, 0, 1, 0);
    vecs[11] = v(0, '0,    1, 1, 32'hCCDDEEFF, 0, 1, 0);
    vecs[12] = v(0, '0,    1, 0, 32'h0,        0, 0, 0);

    rst_n = 1'b0; clr = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
    #1;
    check("reset_state", {out_valid, out_data, out_last, fifo_cnt, stall}, 38'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single block then backpressure 1,0,0,1 mid-block
    for (int i = 0; i < 13; i++) begin
      res_valid = vecs[i].rv;
      res_data  = vecs[i].data;
      out_ready = vecs[i].ordy;
      check($sformatf("vec%0d", i), {out_valid, out_data, out_last, fifo_cnt, stall},
            {vecs[i].ov, vecs[i].od, vecs[i].last, vecs[i].cnt, vecs[i].stall});
      step();
    end

    // Fill to full with out_ready low; fifth result is held on the inputs
    out_ready = 1'b0;
    res_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      res_data = mk(k, 1'b0);
      step();
    end
    check("fill_cnt", {fifo_cnt, stall}, {3'd4, 1'b1});
    check("fill_head", {out_valid, out_data}, {1'b1, wd(0, 0)});
    res_data = mk(4, 1'b1);
    step();
    check("fill_hold", {fifo_cnt, stall}, {3'd4, 1'b1});
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("drain%0d", i), {out_valid, out_data, out_last},
            {1'b1, wd(i / 4, i % 4), (i == 19)});
      if (i == 3) check("drain_stall_at_pop", {fifo_cnt, stall}, {3'd4, 1'b1});
      if (i == 4) check("drain_after_pop", {fifo_cnt, stall}, {3'd3, 1'b0});
      if (i == 5) check("drain_5th_taken", {fifo_cnt, stall}, {3'd4, 1'b1});
      step();
      if (i == 4) res_valid = 1'b0;
    end
    check("drain_empty", {out_valid, fifo_cnt, stall}, {1'b0, 3'd0, 1'b0});

    // Pointer wrap: 10 blocks, one every 4 cycles, eop only on the last
    out_ready = 1'b1;
    pushed = 0; n_last = 0; n_words = 0;
    for (int c = 0; c < 48; c++) begin
      res_valid = (c % 4 == 0) && (pushed < 10);
      res_data  = mk(10 + pushed, pushed == 9);
      if (out_valid) begin
        n_words++;
        if (exp_q.size() == 0) check("wrap_extra_word", {32'h0, out_data}, 64'h0);
        else check($sformatf("wrap_w%0d", n_words), {32'h0, out_data}, {32'h0, exp_q.pop_front()});
        if (out_last) begin
          n_last++;
          check("wrap_last_pos", 64'(n_words), 64'd40);
        end
      end
      if (res_valid) begin
        check($sformatf("wrap_nostall%0d", pushed), {63'h0, stall}, 64'h0);
        for (int w = 0; w < 4; w++) exp_q.push_back(wd(10 + pushed, w));
        pushed++;
      end
      step();
    end
    res_valid = 1'b0;
    check("wrap_words", 64'(n_words), 64'd40);
    check("wrap_lasts", 64'(n_last), 64'd1);
    check("wrap_idle", {out_valid, fifo_cnt}, {1'b0, 3'd0});

    // clr with 2 entries, word_idx=2, and a simultaneous push
    out_ready = 1'b0;
    res_valid = 1'b1;
    res_data  = mk(20, 1'b0); step();
    res_data  = mk(21, 1'b0); step();
    res_valid = 1'b0;
    out_ready = 1'b1;
    step(); step();
    check("clr_pre", {out_data, fifo_cnt}, {wd(20, 2), 3'd2});
    clr = 1'b1; res_valid = 1'b1; res_data = mk(22, 1'b1);
    step();
    clr = 1'b0; res_valid = 1'b0;
    check("clr_post", {out_valid, out_data, out_last, fifo_cnt, stall}, 38'h0);
    step(); step();
    check("clr_no_emit", {out_valid, fifo_cnt}, {1'b0, 3'd0});
    res_valid = 1'b1; res_data = mk(23, 1'b0);
    step();
    res_valid = 1'b0;
    check("clr_next_block", {out_valid, out_data}, {1'b1, wd(23, 0)});
    step(); step(); step(); step();

    // Async reset between edges in the middle of a block
    res_valid = 1'b1; res_data = mk(30, 1'b1);
    step();
    res_valid = 1'b0;
    step();
    check("rst_pre", {out_valid, out_data}, {1'b1, wd(30, 1)});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {out_valid, out_data, out_last, fifo_cnt, stall}, 38'h0);
    step();
    #2 rst_n = 1'b1;
    step();
    check("rst_after", {out_valid, fifo_cnt}, {1'b0, 3'd0});
    res_valid = 1'b1; res_data = mk(31, 1'b0);
    step();
    res_valid = 1'b0;
    check("rst_first", {out_valid, out_data}, {1'b1, wd(31, 0)});
    repeat (4) step();

`ifdef RESULT_UNPACK_BLK_CNT_EN
    #2 rst_n = 1'b0;
    #1;
    check("cnt_reset", {blk_cnt, pkt_cnt}, 48'h0);
    step();
    #2 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    res_valid = 1'b1;
    res_data = mk(40, 1'b0); step();
    res_data = mk(41, 1'b1); step();
    res_data = mk(42, 1'b0); step();
    res_valid = 1'b0;
    repeat (14) step();
    check("cnt_values", {fifo_cnt, blk_cnt, pkt_cnt}, {3'd0, 32'd3, 16'd1});
    #2 rst_n = 1'b0;
    #1;
    check("cnt_after_reset", {blk_cnt, pkt_cnt}, 48'h0);
    step();
    #2 rst_n = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
